bf_mem_bus: RTL and testbench
=============================

Name: bf_mem_bus

Overview:
- Memory-port adapter between the BF core (FSM plus datapath) and off-chip program/tape memory.
- Accepts one byte read or write per request from the core and serialises it over an 8-bit shared pin bus in three beats: address-high, address-low, data.
- Uses a 4-phase strobe/ack handshake on the pins.
- Its `req_ready` is the core's `en` gating source: the core stalls until `rsp_valid`.

Parameters:
- ADDR_W, 16, core address width; legal range 9..16; the high beat carries addr[ADDR_W-1:8] zero-padded to 8 bits.
- TIMEOUT_CYC, 255, maximum cycles waiting on one ack edge before abort (used only with the optional feature).

Ports:
- clk  in  1  clock
- nreset  in  1  reset, synchronous, active-low
- req_valid  in  1  core requests an access
- req_ready  out  1  high only in IDLE; request accepted when req_valid && req_ready
- req_write  in  1  1 = write, 0 = read
- req_addr  in  ADDR_W  byte address
- req_wdata  in  8  write data
- rsp_valid  out  1  one-cycle pulse: access complete
- rsp_rdata  out  8  read data, held until the next rsp_valid
- bus_out  out  8  pin output byte
- bus_oe  out  8  pin output enables, all-1s or all-0s
- bus_in  in  8  pin input byte
- bus_phase  out  2  0 = ADDR_HI, 1 = ADDR_LO, 2 = DATA, 3 = idle
- bus_strobe  out  1  beat-valid strobe
- bus_we  out  1  registered copy of req_write for the current transaction
- bus_ack  in  1  asynchronous acknowledge from the memory device
- err  out  1  sticky timeout flag

Behaviour:
- All outputs are registered.
- Reset (synchronous, any state, including mid-transaction) sets:
  - state IDLE, req_ready 1, rsp_valid 0, rsp_rdata 0x00
  - bus_strobe 0, bus_oe 0x00, bus_out 0x00, bus_phase 3, bus_we 0, err 0
- bus_ack passes through a 2-flop synchroniser; ack_s is the synchronised value. All ack decisions use ack_s.
- On acceptance, addr, write and wdata are latched. Later changes on the req_* inputs are ignored until the next acceptance.
- State machine:
  - IDLE: on accept -> BEAT with beat=0.
  - BEAT: drive bus_phase=beat and bus_strobe=1.
    - bus_out is addr_hi, addr_lo or wdata, by beat.
    - bus_oe=0xFF, except on a read DATA beat, where bus_oe=0x00.
    - Stay until ack_s==1. On a read DATA beat, capture bus_in into rsp_rdata in the same cycle ack_s==1 is seen.
    - Then -> RELEASE.
  - RELEASE: bus_strobe=0, bus_oe unchanged. Wait for ack_s==0.
    - If beat<2: beat++ -> BEAT.
    - Otherwise -> RESP.
  - RESP: rsp_valid=1 for one cycle, bus_oe=0x00, bus_phase=3 -> IDLE.
- Write transactions leave rsp_rdata unchanged.
- Latency with a zero-delay device (ack follows strobe combinationally): 3 beats × (1 strobe cycle + 2 sync + 1 release + 2 sync) + accept + RESP. The bench derives the exact count from the RTL and pins it in a golden value.
- req_ready=0 from the cycle after accept through the RESP cycle. It returns to 1 in the cycle after rsp_valid, so back-to-back requests lose no extra cycle.
- ack_s already 1 when a beat starts (device still asserting from the previous beat): impossible by construction, because RELEASE waits for 0.
- A glitch on bus_ack shorter than one clock may be missed. This is legal; the device must hold ack until strobe falls.

Optional Feature:
- Macro: BF_MEM_TIMEOUT_EN.
- Defined:
  - A counter (width clog2(TIMEOUT_CYC+1)) clears on entering BEAT or RELEASE and increments each cycle spent waiting.
  - On reaching TIMEOUT_CYC: strobe drops and bus_oe=0x00, err sets (sticky until reset), then RESP issues rsp_valid with rsp_rdata=0xFF (reads only).
  - After the abort, the state returns to IDLE.
- Undefined: waits forever; err is tied 0; the counter logic is absent.

Decomposition:
- Package bf_pkg holds:
  - bus_phase encodings (PH_ADDR_HI, PH_ADDR_LO, PH_DATA, PH_IDLE)
  - FSM state localparams
  - the 0xFF abort data constant
- One sub-module, bf_sync2: a 2-flop synchroniser, reset to 0 by nreset.

Test Plan:
- Read, ADDR_W=16: request addr 0x1234 with a zero-delay device returning 0x5A -> beats show bus_out 0x12, then 0x34, then oe=0x00; a single rsp_valid pulse with rsp_rdata=0x5A.
- Write: addr 0x00FF, wdata 0xC3 -> DATA beat shows bus_out=0xC3, oe=0xFF, bus_we=1; rsp_rdata keeps its previous value.
- Slow device: ack delayed 10 cycles per edge -> strobe held throughout, no early advance, correct data, req_ready=0 until after rsp_valid.
- Back-to-back: req_valid held high for 3 requests -> exactly 3 rsp_valid pulses, each acceptance in the cycle after the prior rsp_valid.
- Reset mid-transaction: nreset low during the ADDR_LO beat -> next edge gives strobe 0, oe 0x00, req_ready 1; no rsp_valid.
- With BF_MEM_TIMEOUT_EN, TIMEOUT_CYC=8, ack never asserted -> strobe drops after 8 wait cycles, err=1, rsp_valid with rsp_rdata=0xFF, err persists until nreset.

Source files
------------

// File: rtl/bf_pkg.sv
// Shared encodings for the BF memory-port adapter: bus phase codes, FSM states
// and the byte returned to the core when an access is aborted.
package bf_pkg;

    localparam logic [1:0] PH_ADDR_HI = 2'd0;
    localparam logic [1:0] PH_ADDR_LO = 2'd1;
    localparam logic [1:0] PH_DATA    = 2'd2;
    localparam logic [1:0] PH_IDLE    = 2'd3;

    localparam logic [7:0] ABORT_DATA = 8'hFF;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BEAT    = 2'd1,
        ST_RELEASE = 2'd2,
        ST_RESP    = 2'd3
    } bf_state_t;

endpackage

// File: rtl/bf_sync2.sv
// Two-flop synchroniser for the asynchronous memory acknowledge.
// Both stages clear synchronously while nreset is low.
module bf_sync2 (
    input  logic clk,
    input  logic nreset,
    input  logic d,
    output logic q
);
    logic meta;

    always_ff @(posedge clk) begin
        if (!nreset) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/bf_mem_bus.sv
// BF core memory port: serialises one byte access into ADDR_HI/ADDR_LO/DATA
// strobe/ack beats on a shared 8-bit pin bus. Define BF_MEM_TIMEOUT_EN for ack-timeout abort.
//
// state   | meaning
// IDLE    | req_ready high, waiting for a core request
// BEAT    | strobe high for the current beat, waiting for ack_s
// RELEASE | strobe low, waiting for ack_s to drop before the next beat
// RESP    | rsp_valid pulse to the core, bus released
module bf_mem_bus
    import bf_pkg::*;
#(
    parameter int ADDR_W      = 16,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic              clk,
    input  logic              nreset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [7:0]        req_wdata,
    output logic              rsp_valid,
    output logic [7:0]        rsp_rdata,
    output logic [7:0]        bus_out,
    output logic [7:0]        bus_oe,
    input  logic [7:0]        bus_in,
    output logic [1:0]        bus_phase,
    output logic              bus_strobe,
    output logic              bus_we,
    input  logic              bus_ack,
    output logic              err
);
    bf_state_t         state_q, state_d;
    logic [1:0]        beat_q, beat_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        wdata_q, wdata_d;
    logic              ready_d, rsp_valid_d, strobe_d, we_d, err_d;
    logic [7:0]        rdata_d, out_d, oe_d;
    logic [1:0]        phase_d;
    logic              ack_s;
    logic              abort;

    bf_sync2 u_ack_sync (
        .clk    (clk),
        .nreset (nreset),
        .d      (bus_ack),
        .q      (ack_s)
    );

    function automatic logic [7:0] beat_byte(input logic [1:0]        beat,
                                             input logic [ADDR_W-1:0] addr,
                                             input logic [7:0]        wdata);
        logic [7:0] b;
        case (beat)
            PH_ADDR_HI: b = 8'(addr[ADDR_W-1:8]);
            PH_ADDR_LO: b = addr[7:0];
            default:    b = wdata;
        endcase
        return b;
    endfunction

    // The device drives the pins only during the DATA beat of a read.
    function automatic logic [7:0] beat_oe(input logic [1:0] beat, input logic write);
        return (beat == PH_DATA && !write) ? 8'h00 : 8'hFF;
    endfunction

`ifdef BF_MEM_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;

    always_comb begin
        wait_cnt_d = '0;
        abort      = 1'b0;
        if ((state_q == ST_BEAT && !ack_s) || (state_q == ST_RELEASE && ack_s)) begin
            wait_cnt_d = wait_cnt_q + CNT_W'(1);
            abort      = (wait_cnt_q == CNT_W'(TIMEOUT_CYC - 1));
        end
    end

    always_ff @(posedge clk) begin
        if (!nreset) begin
            wait_cnt_q <= '0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
        end
    end
`else
    logic [31:0] timeout_unused;
    assign timeout_unused = TIMEOUT_CYC;
    assign abort          = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        beat_d      = beat_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        ready_d     = req_ready;
        rsp_valid_d = 1'b0;
        rdata_d     = rsp_rdata;
        out_d       = bus_out;
        oe_d        = bus_oe;
        phase_d     = bus_phase;
        strobe_d    = bus_strobe;
        we_d        = bus_we;
        err_d       = err;

        case (state_q)
            ST_IDLE: begin
                if (req_valid && req_ready) begin
                    state_d  = ST_BEAT;
                    beat_d   = PH_ADDR_HI;
                    addr_d   = req_addr;
                    wdata_d  = req_wdata;
                    we_d     = req_write;
                    ready_d  = 1'b0;
                    strobe_d = 1'b1;
                    phase_d  = PH_ADDR_HI;
                    out_d    = beat_byte(PH_ADDR_HI, req_addr, req_wdata);
                    oe_d     = 8'hFF;
                end
            end
            ST_BEAT: begin
                if (ack_s) begin
                    state_d  = ST_RELEASE;
                    strobe_d = 1'b0;
                    if (beat_q == PH_DATA && !bus_we) begin
                        rdata_d = bus_in;
                    end
                end
            end
            ST_RELEASE: begin
                if (!ack_s) begin
                    if (beat_q != PH_DATA) begin
                        state_d  = ST_BEAT;
                        beat_d   = beat_q + 2'd1;
                        strobe_d = 1'b1;
                        phase_d  = beat_d;
                        out_d    = beat_byte(beat_d, addr_q, wdata_q);
                        oe_d     = beat_oe(beat_d, bus_we);
                    end else begin
                        state_d     = ST_RESP;
                        rsp_valid_d = 1'b1;
                        oe_d        = 8'h00;
                        phase_d     = PH_IDLE;
                    end
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
                ready_d = 1'b1;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Abort overrides the normal wait: release the bus and answer the core at once.
        if (abort) begin
            state_d     = ST_RESP;
            rsp_valid_d = 1'b1;
            strobe_d    = 1'b0;
            oe_d        = 8'h00;
            phase_d     = PH_IDLE;
            err_d       = 1'b1;
            if (!bus_we) begin
                rdata_d = ABORT_DATA;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!nreset) begin
            state_q    <= ST_IDLE;
            beat_q     <= PH_ADDR_HI;
            addr_q     <= '0;
            wdata_q    <= 8'h00;
            req_ready  <= 1'b1;
            rsp_valid  <= 1'b0;
            rsp_rdata  <= 8'h00;
            bus_out    <= 8'h00;
            bus_oe     <= 8'h00;
            bus_phase  <= PH_IDLE;
            bus_strobe <= 1'b0;
            bus_we     <= 1'b0;
            err        <= 1'b0;
        end else begin
            state_q    <= state_d;
            beat_q     <= beat_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            req_ready  <= ready_d;
            rsp_valid  <= rsp_valid_d;
            rsp_rdata  <= rdata_d;
            bus_out    <= out_d;
            bus_oe     <= oe_d;
            bus_phase  <= phase_d;
            bus_strobe <= strobe_d;
            bus_we     <= we_d;
            err        <= err_d;
        end
    end

endmodule

// File: tb/tb_bf_mem_bus.sv
// Scoreboard bench for bf_mem_bus: a behavioural memory model predicts responses and
// beats; a device model answers the pin bus with configurable ack delay.
module tb_bf_mem_bus;
    import bf_pkg::*;

    localparam int ADDR_W   = 16;
    localparam int TO_CYC   = 8;
    localparam int ZERO_LAT = 18;

    logic              clk = 1'b0;
    logic              nreset = 1'b0;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic              req_write = 1'b0;
    logic [ADDR_W-1:0] req_addr = '0;
    logic [7:0]        req_wdata = 8'h00;
    logic              rsp_valid;
    logic [7:0]        rsp_rdata;
    logic [7:0]        bus_out;
    logic [7:0]        bus_oe;
    logic [7:0]        bus_in;
    logic [1:0]        bus_phase;
    logic              bus_strobe;
    logic              bus_we;
    logic              bus_ack;
    logic              err;

    always #5 clk = ~clk;

    bf_mem_bus #(.ADDR_W(ADDR_W), .TIMEOUT_CYC(TO_CYC)) dut (
        .clk        (clk),
        .nreset     (nreset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .bus_out    (bus_out),
        .bus_oe     (bus_oe),
        .bus_in     (bus_in),
        .bus_phase  (bus_phase),
        .bus_strobe (bus_strobe),
        .bus_we     (bus_we),
        .bus_ack    (bus_ack),
        .err        (err)
    );

    typedef struct {
        logic [1:0] phase;
        logic [7:0] out;
        logic       chk_out;
        logic [7:0] oe;
        logic       we;
    } beat_t;

    typedef struct {
        logic [7:0] rdata;
        int         acc_cyc;
        int         lat;
    } rsp_t;

    beat_t      beat_q[$];
    rsp_t       exp_q[$];
    logic [7:0] model_mem [logic [15:0]];
    logic [7:0] dev_mem [65536];
    bit         dev_written [65536];
    logic [7:0] dev_hi, dev_lo;
    logic [15:0] pool [6];

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    bit   zero_dly = 1'b1;
    bit   never_ack = 1'b0;
    bit   expect_abort = 1'b0;
    bit   chk_b2b = 1'b0;
    int   ack_dly = 1;
    logic ack_r = 1'b0;
    logic ack_hit = 1'b0;
    logic prev_strobe = 1'b0;
    int   hi_cnt = 0;
    int   dcnt = 0;
    int   acc_cnt = 0;
    int   rsp_cnt = 0;
    int   last_rsp_cyc = -10;
    logic prev_rsp = 1'b0;
    logic [7:0] last_rdata = 8'h00;
    logic exp_err = 1'b0;

    // Unwritten locations read back as a fixed function of the address (0x1234 -> 0x5A).
    function automatic logic [7:0] init_val(input logic [15:0] a);
        return a[15:8] ^ a[7:0] ^ 8'h7C;
    endfunction

    assign bus_ack = zero_dly ? bus_strobe : ack_r;
    assign bus_in  = dev_written[{dev_hi, dev_lo}] ? dev_mem[{dev_hi, dev_lo}]
                                                   : init_val({dev_hi, dev_lo});

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Memory device model: checks each beat, stores writes, answers with an ack.
    always @(negedge clk) begin
        beat_t e;
        if (!nreset) begin
            beat_q.delete();
            prev_strobe = 1'b0;
            ack_r       = 1'b0;
            dcnt        = 0;
            hi_cnt      = 0;
        end else begin
            if (bus_strobe && !prev_strobe) begin
                hi_cnt  = 0;
                ack_hit = 1'b0;
                if (!zero_dly) check("ack_low_at_start", ack_r, 0);
                if (beat_q.size() == 0) begin
                    check("beat_unexpected", bus_phase, PH_IDLE);
                end else begin
                    e = beat_q.pop_front();
                    check("beat_phase", bus_phase, e.phase);
                    check("beat_oe", bus_oe, e.oe);
                    check("beat_we", bus_we, e.we);
                    if (e.chk_out) check("beat_out", bus_out, e.out);
                end
                if (bus_phase == PH_ADDR_HI) dev_hi = bus_out;
                if (bus_phase == PH_ADDR_LO) dev_lo = bus_out;
                if (bus_phase == PH_DATA && bus_we) begin
                    dev_mem[{dev_hi, dev_lo}]     = bus_out;
                    dev_written[{dev_hi, dev_lo}] = 1'b1;
                end
            end
            if (bus_strobe) begin
                hi_cnt++;
                if (bus_ack) ack_hit = 1'b1;
            end
            if (!bus_strobe && prev_strobe) begin
                if (expect_abort) check("abort_strobe_cycles", hi_cnt, TO_CYC);
                else              check("strobe_held_until_ack", ack_hit, 1);
            end
            if (!zero_dly && !never_ack) begin
                if (ack_r != bus_strobe) begin
                    dcnt++;
                    if (dcnt >= ack_dly) begin
                        ack_r = bus_strobe;
                        dcnt  = 0;
                    end
                end else begin
                    dcnt = 0;
                end
            end
            prev_strobe = bus_strobe;
        end
    end

    // Response monitor: pops the scoreboard on every rsp_valid.
    always @(negedge clk) begin
        rsp_t r;
        if (!nreset) begin
            exp_q.delete();
            rsp_cnt  = acc_cnt;
            prev_rsp = 1'b0;
        end else begin
            if (acc_cnt != rsp_cnt) check("ready_low_busy", req_ready, 0);
            if (rsp_valid) begin
                check("rsp_single_pulse", prev_rsp, 0);
                if (exp_q.size() == 0) begin
                    check("rsp_unexpected", rsp_valid, 0);
                end else begin
                    r = exp_q.pop_front();
                    check("rsp_rdata", rsp_rdata, r.rdata);
                    if (r.lat >= 0) check("rsp_latency", cyc - r.acc_cyc, r.lat);
                    check("rsp_err", err, exp_err);
                end
                last_rsp_cyc = cyc;
                rsp_cnt++;
            end
            prev_rsp = rsp_valid;
        end
    end

    task automatic issue(input logic w, input logic [15:0] a, input logic [7:0] d, input bit keep);
        int    g;
        beat_t b;
        rsp_t  r;
        g = 0;
        req_valid = 1'b1;
        req_write = w;
        req_addr  = a;
        req_wdata = d;
        while (!req_ready && g < 1000) begin
            @(negedge clk);
            g++;
        end
        check("accept_ready", req_ready, 1);
        if (!req_ready) begin
            req_valid = 1'b0;
            return;
        end
        if (chk_b2b) check("b2b_accept_cycle", cyc, last_rsp_cyc + 1);
        b.we = w;
        b.phase = PH_ADDR_HI; b.out = a[15:8]; b.chk_out = 1'b1; b.oe = 8'hFF;
        beat_q.push_back(b);
        if (!expect_abort) begin
            b.phase = PH_ADDR_LO; b.out = a[7:0];
            beat_q.push_back(b);
            b.phase = PH_DATA; b.out = d; b.chk_out = w; b.oe = w ? 8'hFF : 8'h00;
            beat_q.push_back(b);
        end
        if (expect_abort)   r.rdata = w ? last_rdata : ABORT_DATA;
        else if (w)         r.rdata = last_rdata;
        else                r.rdata = model_mem.exists(a) ? model_mem[a] : init_val(a);
        if (w && !expect_abort) model_mem[a] = d;
        last_rdata = r.rdata;
        r.acc_cyc  = cyc + 1;
        r.lat      = expect_abort ? TO_CYC : (zero_dly ? ZERO_LAT : -1);
        exp_q.push_back(r);
        @(posedge clk);
        #1;
        acc_cnt++;
        req_addr  = 16'($urandom);
        req_wdata = 8'($urandom);
        req_write = 1'($urandom);
        if (!keep) req_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic drain();
        int g;
        g = 0;
        while (exp_q.size() != 0 && g < 600) begin
            @(negedge clk);
            g++;
        end
        check("drain_done", exp_q.size(), 0);
        repeat (3) @(negedge clk);
    endtask

    task automatic reset_checks(input string tag);
        check({tag, "_req_ready"}, req_ready, 1);
        check({tag, "_rsp_valid"}, rsp_valid, 0);
        check({tag, "_rsp_rdata"}, rsp_rdata, 8'h00);
        check({tag, "_strobe"}, bus_strobe, 0);
        check({tag, "_oe"}, bus_oe, 8'h00);
        check({tag, "_out"}, bus_out, 8'h00);
        check({tag, "_phase"}, bus_phase, PH_IDLE);
        check({tag, "_we"}, bus_we, 0);
        check({tag, "_err"}, err, 0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int g;
        int m;
        pool[0] = 16'h1234; pool[1] = 16'h00FF; pool[2] = 16'h2345;
        pool[3] = 16'hFF00; pool[4] = 16'h8001; pool[5] = 16'h0000;

        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_checks("reset");
        nreset = 1'b1;
        repeat (2) @(negedge clk);

        // Directed read / write with a zero-delay device.
        zero_dly = 1'b1;
        issue(1'b0, 16'h1234, 8'h00, 1'b0);
        drain();
        check("read_1234_data", rsp_rdata, 8'h5A);
        issue(1'b1, 16'h00FF, 8'hC3, 1'b0);
        drain();
        check("write_keeps_rdata", rsp_rdata, 8'h5A);
        issue(1'b0, 16'h00FF, 8'h00, 1'b0);
        drain();

        // Slow device: ack follows each strobe edge after 10 cycles.
        zero_dly = 1'b0; ack_dly = 10;
        issue(1'b0, 16'h1234, 8'h00, 1'b0);
        drain();
        issue(1'b1, 16'h2345, 8'hA7, 1'b0);
        drain();
        issue(1'b0, 16'h2345, 8'h00, 1'b0);
        drain();

        // Back-to-back requests with req_valid held high.
        zero_dly = 1'b1;
        chk_b2b = 1'b0;
        issue(1'b1, 16'hFF00, 8'h3C, 1'b1);
        chk_b2b = 1'b1;
        issue(1'b0, 16'hFF00, 8'h00, 1'b1);
        issue(1'b0, 16'h1234, 8'h00, 1'b0);
        chk_b2b = 1'b0;
        drain();

        // Randomised traffic over a small address pool.
        for (int i = 0; i < 30; i++) begin
            m = int'($urandom_range(0, 4));
            zero_dly = (m == 0);
            ack_dly  = (m == 4) ? 10 : m;
            issue(1'($urandom), pool[$urandom_range(0, 5)], 8'($urandom), 1'b0);
            drain();
        end

        // Reset during the ADDR_LO beat.
        zero_dly = 1'b1;
        issue(1'b0, 16'h1234, 8'h00, 1'b0);
        g = 0;
        while (!(bus_strobe && bus_phase == PH_ADDR_LO) && g < 50) begin
            @(negedge clk);
            g++;
        end
        check("reach_addr_lo", bus_phase, PH_ADDR_LO);
        nreset = 1'b0;
        @(negedge clk);
        reset_checks("midreset");
        @(negedge clk);
        nreset = 1'b1;
        last_rdata = 8'h00;
        repeat (30) @(negedge clk);
        issue(1'b0, 16'h00FF, 8'h00, 1'b0);
        drain();

`ifdef BF_MEM_TIMEOUT_EN
        // Device that never acknowledges: abort after TO_CYC wait cycles.
        zero_dly = 1'b0; never_ack = 1'b1; expect_abort = 1'b1; exp_err = 1'b1;
        issue(1'b0, 16'h0042, 8'h00, 1'b0);
        drain();
        repeat (5) @(negedge clk);
        check("err_sticky", err, 1);
        check("abort_ready", req_ready, 1);
        nreset = 1'b0;
        @(negedge clk);
        reset_checks("abort_reset");
        @(negedge clk);
        nreset = 1'b1;
        never_ack = 1'b0; expect_abort = 1'b0; exp_err = 1'b0; zero_dly = 1'b1;
        last_rdata = 8'h00;
        issue(1'b0, 16'h1234, 8'h00, 1'b0);
        drain();
`else
        check("err_tied_low", err, 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
